wb_fifo_test_slave: RTL and testbench

Wishbone-slave register bank wrapping two FIFOs between a host bus and device-side logic. The timestamp FIFO (TSF) is filled by the device and drained by the host over Wishbone. The memory-access FIFO (MEMACC) is filled by the host and drained by the device. It sits on the host Wishbone bus as a 6-register peripheral, with direct FIFO strobes and status on the device side.

---
 rtl/wb_fifo_test_slave.sv | 193 +++++++++++++++++++
 tb/tb_wb_fifo_test_slave.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_fifo_test_slave.sv
// wb_fifo_test_slave
// Wishbone register bank wrapping two FIFOs between a host bus and device logic.
//   TSF    (256 x 53): filled by the device strobe, drained by host reads of TSF_R1.
//   MEMACC (32 x 33) : filled by host writes of MEMACC_R1, drained by the device strobe.
// Ports:
//   wb_clk_i, rst_n_i (asynchronous, active-high despite the name)
//   wb_addr_i/wb_data_i/wb_data_o/wb_cyc_i/wb_stb_i/wb_we_i/wb_sel_i/wb_ack_o : classic Wishbone slave
//   ft_tsf_*    : TSF push strobe, entry fields and status
//   ft_memacc_* : MEMACC pop strobe, status and popped entry (held until the next pop)
// Register map: 0 TSF_R0, 1 TSF_R1 (read pops), 2 TSF_CSR, 3 MEMACC_R0, 4 MEMACC_R1 (write pushes),
//               5 MEMACC_CSR, 6/7 read as zero.
module wb_fifo_test_slave (
  input  logic        wb_clk_i,
  input  logic        rst_n_i,
  input  logic [2:0]  wb_addr_i,
  input  logic [31:0] wb_data_i,
  output logic [31:0] wb_data_o,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  output logic        wb_ack_o,
  input  logic        ft_tsf_wr_req_i,
  input  logic [27:0] ft_tsf_val_r_i,
  input  logic [3:0]  ft_tsf_val_f_i,
  input  logic [4:0]  ft_tsf_pid_i,
  input  logic [15:0] ft_tsf_fid_i,
  output logic        ft_tsf_wr_full_o,
  output logic        ft_tsf_wr_empty_o,
  output logic [7:0]  ft_tsf_wr_usedw_o,
  input  logic        ft_memacc_rd_req_i,
  output logic        ft_memacc_rd_full_o,
  output logic        ft_memacc_rd_empty_o,
  output logic [4:0]  ft_memacc_rd_usedw_o,
  output logic        ft_memacc_ad_sel_o,
  output logic [31:0] ft_memacc_ad_o
);

  // Byte selects carry no meaning here: every access is full-word.
  logic w_sel_unused;
  assign w_sel_unused = ^wb_sel_i;

  // ---------------------------------------------------------------------------
  // Wishbone handshake: one access per cyc&stb, ack one clock later for one cycle.
  // ---------------------------------------------------------------------------
  logic        r_ack;
  logic        w_access;
  logic        w_bus_rd;
  logic        w_bus_wr;

  assign w_access = wb_cyc_i & wb_stb_i & ~r_ack;
  assign w_bus_rd = w_access & ~wb_we_i;
  assign w_bus_wr = w_access &  wb_we_i;

  // ---------------------------------------------------------------------------
  // TSF storage. Entry layout {fid, pid, val_f, val_r} puts TSF_R0 in bits [31:0].
  // ---------------------------------------------------------------------------
  logic [52:0] r_tsf_mem [0:255];
  logic [7:0]  r_tsf_wptr;
  logic [7:0]  r_tsf_rptr;
  logic [8:0]  r_tsf_cnt;
  logic        w_tsf_full;
  logic        w_tsf_empty;
  logic        w_tsf_push;
  logic        w_tsf_pop;
  logic [52:0] w_tsf_head;

  assign w_tsf_full  = (r_tsf_cnt == 9'd256);
  assign w_tsf_empty = (r_tsf_cnt == 9'd0);
  // A push on a full FIFO is dropped even when a pop happens on the same edge.
  assign w_tsf_push  = ft_tsf_wr_req_i & ~w_tsf_full;
  assign w_tsf_pop   = w_bus_rd & (wb_addr_i == 3'd1) & ~w_tsf_empty;
  // First-word-fall-through: the head is always visible, masked to zero when empty.
  assign w_tsf_head  = w_tsf_empty ? 53'd0 : r_tsf_mem[r_tsf_rptr];

  always_ff @(posedge wb_clk_i) begin
    if (w_tsf_push)
      r_tsf_mem[r_tsf_wptr] <= {ft_tsf_fid_i, ft_tsf_pid_i, ft_tsf_val_f_i, ft_tsf_val_r_i};
  end

  always_ff @(posedge wb_clk_i or posedge rst_n_i) begin
    if (rst_n_i) begin
      r_tsf_wptr <= 8'd0;
      r_tsf_rptr <= 8'd0;
      r_tsf_cnt  <= 9'd0;
    end else begin
      if (w_tsf_push) r_tsf_wptr <= r_tsf_wptr + 8'd1;
      if (w_tsf_pop)  r_tsf_rptr <= r_tsf_rptr + 8'd1;
      case ({w_tsf_push, w_tsf_pop})
        2'b10:   r_tsf_cnt <= r_tsf_cnt + 9'd1;
        2'b01:   r_tsf_cnt <= r_tsf_cnt - 9'd1;
        default: r_tsf_cnt <= r_tsf_cnt;
      endcase
    end
  end

  assign ft_tsf_wr_full_o  = w_tsf_full;
  assign ft_tsf_wr_empty_o = w_tsf_empty;
  assign ft_tsf_wr_usedw_o = r_tsf_cnt[7:0];

  // ---------------------------------------------------------------------------
  // MEMACC staging registers and storage.
  // ---------------------------------------------------------------------------
  logic        r_mem_r0;
  logic [31:0] r_mem_r1;
  logic [32:0] r_mem_mem [0:31];
  logic [4:0]  r_mem_wptr;
  logic [4:0]  r_mem_rptr;
  logic [5:0]  r_mem_cnt;
  logic        w_mem_full;
  logic        w_mem_empty;
  logic        w_mem_push;
  logic        w_mem_pop;
  logic        r_ad_sel;
  logic [31:0] r_ad;

  assign w_mem_full  = (r_mem_cnt == 6'd32);
  assign w_mem_empty = (r_mem_cnt == 6'd0);
  assign w_mem_push  = w_bus_wr & (wb_addr_i == 3'd4) & ~w_mem_full;
  assign w_mem_pop   = ft_memacc_rd_req_i & ~w_mem_empty;

  // The pushed ad_sel is the staging bit as it stands before this write edge.
  always_ff @(posedge wb_clk_i) begin
    if (w_mem_push)
      r_mem_mem[r_mem_wptr] <= {r_mem_r0, wb_data_i};
  end

  always_ff @(posedge wb_clk_i or posedge rst_n_i) begin
    if (rst_n_i) begin
      r_mem_r0   <= 1'b0;
      r_mem_r1   <= 32'd0;
      r_mem_wptr <= 5'd0;
      r_mem_rptr <= 5'd0;
      r_mem_cnt  <= 6'd0;
      r_ad_sel   <= 1'b0;
      r_ad       <= 32'd0;
    end else begin
      if (w_bus_wr && wb_addr_i == 3'd3) r_mem_r0 <= wb_data_i[0];
      // The staging word updates even when the push itself is dropped.
      if (w_bus_wr && wb_addr_i == 3'd4) r_mem_r1 <= wb_data_i;
      if (w_mem_push) r_mem_wptr <= r_mem_wptr + 5'd1;
      if (w_mem_pop) begin
        r_mem_rptr          <= r_mem_rptr + 5'd1;
        {r_ad_sel, r_ad}    <= r_mem_mem[r_mem_rptr];
      end
      case ({w_mem_push, w_mem_pop})
        2'b10:   r_mem_cnt <= r_mem_cnt + 6'd1;
        2'b01:   r_mem_cnt <= r_mem_cnt - 6'd1;
        default: r_mem_cnt <= r_mem_cnt;
      endcase
    end
  end

  assign ft_memacc_rd_full_o  = w_mem_full;
  assign ft_memacc_rd_empty_o = w_mem_empty;
  assign ft_memacc_rd_usedw_o = r_mem_cnt[4:0];
  assign ft_memacc_ad_sel_o   = r_ad_sel;
  assign ft_memacc_ad_o       = r_ad;

  // ---------------------------------------------------------------------------
  // Read mux and registered bus outputs. Data is captured on the same edge that
  // raises ack, so a TSF_R1 read sees the head before its own pop.
  // ---------------------------------------------------------------------------
  logic [31:0] w_rd_data;
  logic [31:0] r_data;

  always_comb begin
    w_rd_data = 32'd0;
    case (wb_addr_i)
      3'd0: w_rd_data = w_tsf_head[31:0];
      3'd1: w_rd_data = {w_tsf_head[52:37], 11'd0, w_tsf_head[36:32]};
      3'd2: w_rd_data = {14'd0, w_tsf_empty, w_tsf_full, 8'd0, r_tsf_cnt[7:0]};
      3'd3: w_rd_data = {31'd0, r_mem_r0};
      3'd4: w_rd_data = r_mem_r1;
      3'd5: w_rd_data = {14'd0, w_mem_empty, w_mem_full, 11'd0, r_mem_cnt[4:0]};
      default: w_rd_data = 32'd0;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge rst_n_i) begin
    if (rst_n_i) begin
      r_ack  <= 1'b0;
      r_data <= 32'd0;
    end else begin
      r_ack <= w_access;
      if (w_bus_rd) r_data <= w_rd_data;
    end
  end

  assign wb_ack_o  = r_ack;
  assign wb_data_o = r_data;

endmodule

// File: tb/tb_wb_fifo_test_slave.sv
module tb_wb_fifo_test_slave;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  wb_addr = 3'd0;
  logic [31:0] wb_dat_w = 32'd0;
  logic [31:0] wb_dat_r;
  logic        wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
  logic        wb_ack;
  logic        tsf_req = 1'b0;
  logic [27:0] tsf_r = '0;
  logic [3:0]  tsf_f = '0;
  logic [4:0]  tsf_pid = '0;
  logic [15:0] tsf_fid = '0;
  logic        tsf_full, tsf_empty;
  logic [7:0]  tsf_usedw;
  logic        mem_req = 1'b0;
  logic        mem_full, mem_empty;
  logic [4:0]  mem_usedw;
  logic        ad_sel;
  logic [31:0] ad;

  wb_fifo_test_slave dut (
    .wb_clk_i(clk), .rst_n_i(rst),
    .wb_addr_i(wb_addr), .wb_data_i(wb_dat_w), .wb_data_o(wb_dat_r),
    .wb_cyc_i(wb_cyc), .wb_stb_i(wb_stb), .wb_we_i(wb_we), .wb_sel_i(4'hF), .wb_ack_o(wb_ack),
    .ft_tsf_wr_req_i(tsf_req), .ft_tsf_val_r_i(tsf_r), .ft_tsf_val_f_i(tsf_f),
    .ft_tsf_pid_i(tsf_pid), .ft_tsf_fid_i(tsf_fid),
    .ft_tsf_wr_full_o(tsf_full), .ft_tsf_wr_empty_o(tsf_empty), .ft_tsf_wr_usedw_o(tsf_usedw),
    .ft_memacc_rd_req_i(mem_req),
    .ft_memacc_rd_full_o(mem_full), .ft_memacc_rd_empty_o(mem_empty),
    .ft_memacc_rd_usedw_o(mem_usedw),
    .ft_memacc_ad_sel_o(ad_sel), .ft_memacc_ad_o(ad)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [34:0] rq[$];   // expected host reads {addr, data}
  logic [32:0] mq[$];   // expected MEMACC entries {ad_sel, word}
  int          mq_cnt = 0;
  logic        m_r0 = 1'b0;
  logic        tb_rd = 1'b0;
  logic        sink_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", nm, act);
    end
  endtask

  // Read scoreboard monitor: every read ack pops one expectation.
  logic [34:0] mon_e;
  always @(negedge clk) begin
    if (wb_ack && tb_rd) begin
      if (rq.size() == 0) begin
        total++; bad++;
        $display("FAIL rd_unexpected: got 0x%0h expected none", wb_dat_r);
      end else begin
        mon_e = rq.pop_front();
        chk($sformatf("rd[%0d]", mon_e[34:32]), {32'd0, wb_dat_r}, {32'd0, mon_e[31:0]});
      end
    end
  end

  // Device-side MEMACC sink: pops whenever enabled and not empty; checks the
  // entry presented one cycle after each pop edge against the expected queue.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (mem_req) begin
        if (mq.size() == 0) begin
          total++; bad++;
          $display("FAIL sink_unexpected: got sel=%0d ad=0x%0h expected none", ad_sel, ad);
        end else begin
          chk("sink_entry", {31'd0, ad_sel, ad}, {31'd0, mq.pop_front()});
          mq_cnt--;
        end
      end
      mem_req = sink_en && !mem_empty;
    end
  end

  task automatic cycle_wait(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Waits for ack (bounded), releases the bus before the next edge, returns aligned.
  task automatic wait_ack(input string nm, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 8; n++) begin
      @(posedge clk); #1;
      if (wb_ack) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL %s_ack_timeout: got no ack expected ack", nm);
    end
    #5;
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0; tb_rd = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wb_write(input logic [2:0] a, input logic [31:0] d);
    bit ok;
    if (a == 3'd3) m_r0 = d[0];
    if (a == 3'd4 && mq_cnt < 32) begin mq.push_back({m_r0, d}); mq_cnt++; end
    wb_addr = a; wb_dat_w = d; wb_we = 1'b1; wb_cyc = 1'b1; wb_stb = 1'b1;
    wait_ack("wr", ok);
  endtask

  task automatic wb_read(input logic [2:0] a, input logic [31:0] e);
    bit ok;
    rq.push_back({a, e});
    tb_rd = 1'b1;
    wb_addr = a; wb_we = 1'b0; wb_cyc = 1'b1; wb_stb = 1'b1;
    wait_ack("rd", ok);
    if (!ok) void'(rq.pop_front());
  endtask

  task automatic tsf_push(input logic [27:0] r, input logic [3:0] f,
                          input logic [4:0] p, input logic [15:0] fid);
    tsf_r = r; tsf_f = f; tsf_pid = p; tsf_fid = fid; tsf_req = 1'b1;
    @(posedge clk); #1;
    tsf_req = 1'b0;
  endtask

  function automatic logic [31:0] r1_of(input int k);
    logic [15:0] fid;
    logic [4:0]  pid;
    fid = 16'(k + 1000);
    pid = 5'(k);
    return {fid, 11'd0, pid};
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    cycle_wait(1);

    // Reset state
    chk("rst_tsf_flags", {62'd0, tsf_empty, tsf_full}, 64'h2);
    chk("rst_tsf_usedw", {56'd0, tsf_usedw}, 64'd0);
    chk("rst_mem_flags", {62'd0, mem_empty, mem_full}, 64'h2);
    chk("rst_mem_usedw", {59'd0, mem_usedw}, 64'd0);
    chk("rst_ad", {31'd0, ad_sel, ad}, 64'd0);
    chk("rst_ack_data", {31'd0, wb_ack, wb_dat_r}, 64'd0);
    wb_read(3'd2, 32'h0002_0000);
    wb_read(3'd5, 32'h0002_0000);

    // MEMACC streaming to a running sink
    sink_en = 1'b1;
    wb_write(3'd3, 32'd0);
    wb_write(3'd4, 32'd0);
    for (int i = 0; i < 10; i++) begin
      wb_write(3'd3, 32'd1);
      wb_write(3'd4, 32'(3 * i));
    end
    cycle_wait(10);
    chk("stream_left", 64'(mq.size()), 64'd0);
    wb_read(3'd3, 32'd1);
    wb_read(3'd4, 32'd27);

    // MEMACC fill to full with the sink stopped
    sink_en = 1'b0;
    cycle_wait(5);
    wb_write(3'd3, 32'd0);
    for (int i = 0; i < 32; i++) wb_write(3'd4, 32'(100 + i));
    chk("mem_full_flags", {62'd0, mem_empty, mem_full}, 64'h1);
    chk("mem_full_usedw", {59'd0, mem_usedw}, 64'd0);
    wb_write(3'd4, 32'd999);            // dropped push, register still updates
    wb_read(3'd5, 32'h0001_0000);
    wb_read(3'd4, 32'd999);
    sink_en = 1'b1;
    cycle_wait(50);
    chk("mem_drain_left", 64'(mq.size()), 64'd0);
    chk("mem_drain_empty", {63'd0, mem_empty}, 64'd1);

    // TSF single entry
    tsf_push(28'd5, 4'd15, 5'd20, 16'd35);
    wb_read(3'd0, 32'hF000_0005);
    wb_read(3'd1, 32'h0023_0014);
    chk("tsf_empty_after_pop", {63'd0, tsf_empty}, 64'd1);
    wb_read(3'd1, 32'd0);
    wb_read(3'd2, 32'h0002_0000);

    // TSF fill to 256
    for (int k = 0; k < 256; k++) tsf_push(28'(k + 7), 4'(k), 5'(k), 16'(k + 1000));
    chk("tsf_full_flags", {62'd0, tsf_empty, tsf_full}, 64'h1);
    chk("tsf_full_usedw", {56'd0, tsf_usedw}, 64'd0);
    wb_read(3'd2, 32'h0001_0000);
    tsf_push(28'hABCDE, 4'd1, 5'd1, 16'd1);   // dropped
    chk("tsf_257_full", {63'd0, tsf_full}, 64'd1);
    wb_read(3'd0, 32'h0000_0007);
    wb_read(3'd1, r1_of(0));
    chk("tsf_pop1_usedw", {55'd0, tsf_full, tsf_usedw}, 64'd255);
    fork
      tsf_push(28'h1234567, 4'd3, 5'd9, 16'hBEEF);
      wb_read(3'd1, r1_of(1));
    join
    chk("tsf_pushpop_usedw", {55'd0, tsf_full, tsf_usedw}, 64'd255);
    for (int k = 2; k < 256; k++) wb_read(3'd1, r1_of(k));
    wb_read(3'd1, 32'hBEEF_0009);
    wb_read(3'd1, 32'd0);
    chk("tsf_drained_empty", {63'd0, tsf_empty}, 64'd1);

    // Reset during an in-flight access with MEMACC holding 5 entries
    sink_en = 1'b0;
    cycle_wait(3);
    wb_write(3'd3, 32'd1);
    for (int i = 0; i < 5; i++) wb_write(3'd4, 32'(32'h50 + i));
    tsf_push(28'd1, 4'd2, 5'd3, 16'd4);
    chk("pre_rst_mem_usedw", {59'd0, mem_usedw}, 64'd5);
    wb_addr = 3'd5; wb_we = 1'b0; wb_cyc = 1'b1; wb_stb = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("async_rst_mem", {56'd0, mem_empty, mem_full, 1'b0, mem_usedw}, 64'h80);
    chk("async_rst_tsf", {54'd0, tsf_empty, tsf_full, tsf_usedw}, 64'h200);
    for (int n = 0; n < 3; n++) begin
      @(posedge clk); #1;
      chk("rst_no_ack", {63'd0, wb_ack}, 64'd0);
    end
    wb_cyc = 1'b0; wb_stb = 1'b0;
    mq.delete(); mq_cnt = 0; m_r0 = 1'b0;
    rst = 1'b0;
    cycle_wait(1);
    chk("post_rst_ad", {31'd0, ad_sel, ad}, 64'd0);
    wb_read(3'd5, 32'h0002_0000);
    wb_read(3'd3, 32'd0);
    wb_read(3'd4, 32'd0);
    wb_read(3'd0, 32'd0);

    cycle_wait(5);
    chk("rd_queue_left", 64'(rq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
